// File: rtl/ahb_apb_bridge.sv
// ---------------------------------------------------------------------------
// ahb_apb_bridge
//   AHB-Lite responder that terminates single-word AHB transfers and re-issues
//   each one as an APB3 transfer to a single downstream peripheral. Wait
//   states are inserted until the APB transfer completes. PSLVERR or an ACCESS
//   timeout is reported as the AHB two-cycle ERROR response.
//
// Ports
//   HCLK, HRESETn           bus clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS,    AHB address-phase inputs (HREADY is the muxed
//   HWRITE, HREADY          bus-wide ready)
//   HWDATA                  AHB write data (data phase)
//   HRDATA, HREADYOUT,      AHB responder outputs (registered)
//   HRESP
//   PADDR, PSEL, PENABLE,   APB requester outputs (registered)
//   PWRITE, PWDATA
//   PRDATA, PREADY, PSLVERR APB completer inputs
//
// Parameters
//   APB_AW   PADDR width, PADDR = HADDR[APB_AW-1:0]
//   TIMEOUT  max ACCESS cycles waiting for PREADY, 0 disables the timeout
//   CNT_W    timeout counter width, 2**CNT_W must exceed TIMEOUT
// ---------------------------------------------------------------------------
module ahb_apb_bridge #(
    parameter int APB_AW  = 16,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [APB_AW-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [31:0]       PWDATA,
    input  logic [31:0]       PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam bit               TIMEOUT_EN  = (TIMEOUT != 0);

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [APB_AW-1:0]   addr_lat_reg, addr_lat_next;
    logic                write_lat_reg, write_lat_next;
    logic [31:0]         hrdata_reg, hrdata_next;
    logic                hreadyout_reg, hreadyout_next;
    logic                hresp_reg, hresp_next;
    logic [APB_AW-1:0]   paddr_reg, paddr_next;
    logic                psel_reg, psel_next;
    logic                penable_reg, penable_next;
    logic                pwrite_reg, pwrite_next;
    logic [31:0]         pwdata_reg, pwdata_next;

    logic                capture;
    logic [CNT_W-1:0]    cnt_inc;
    logic                unused_inputs;

    // Upper address bits and HTRANS[0] (SEQ vs NONSEQ) carry no meaning here.
    assign unused_inputs = ^{HADDR[31:APB_AW], HTRANS[0]};

    // HREADY qualifies the address phase: a stalled transfer on another
    // slave must not be mistaken for one of ours.
    assign capture = HSEL & HTRANS[1] & HREADY;
    assign cnt_inc = cnt_reg + 1'b1;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            addr_lat_reg  <= '0;
            write_lat_reg <= 1'b0;
            hrdata_reg    <= '0;
            hreadyout_reg <= 1'b1;
            hresp_reg     <= 1'b0;
            paddr_reg     <= '0;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            pwrite_reg    <= 1'b0;
            pwdata_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            addr_lat_reg  <= addr_lat_next;
            write_lat_reg <= write_lat_next;
            hrdata_reg    <= hrdata_next;
            hreadyout_reg <= hreadyout_next;
            hresp_reg     <= hresp_next;
            paddr_reg     <= paddr_next;
            psel_reg      <= psel_next;
            penable_reg   <= penable_next;
            pwrite_reg    <= pwrite_next;
            pwdata_reg    <= pwdata_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        addr_lat_next  = addr_lat_reg;
        write_lat_next = write_lat_reg;
        hrdata_next    = hrdata_reg;
        paddr_next     = paddr_reg;
        pwrite_next    = pwrite_reg;
        pwdata_next    = pwdata_reg;

        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERR2: begin
                if (capture) begin
                    state_next     = ST_LATCH;
                    addr_lat_next  = HADDR[APB_AW-1:0];
                    write_lat_next = HWRITE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_LATCH: begin
                // HWDATA is valid now (AHB data phase); freeze it for APB.
                paddr_next  = addr_lat_reg;
                pwrite_next = write_lat_reg;
                if (write_lat_reg) begin
                    pwdata_next = HWDATA;
                end
                state_next = ST_SETUP;
            end
            ST_SETUP: begin
                cnt_next   = '0;
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    if (PSLVERR) begin
                        state_next = ST_ERR1;
                    end else begin
                        state_next = ST_DONE;
                        if (!pwrite_reg) begin
                            hrdata_next = PRDATA;
                        end
                    end
                end else begin
                    cnt_next = cnt_inc;
                    // cnt_inc equals the number of PREADY=0 ACCESS cycles so far.
                    if (TIMEOUT_EN && (cnt_inc == TIMEOUT_CNT)) begin
                        state_next = ST_ERR1;
                    end
                end
            end
            ST_ERR1: begin
                state_next = ST_ERR2;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Outputs are a registered decode of the state being entered.
        hreadyout_next = (state_next == ST_IDLE) || (state_next == ST_DONE) ||
                         (state_next == ST_ERR2);
        hresp_next     = (state_next == ST_ERR1) || (state_next == ST_ERR2);
        psel_next      = (state_next == ST_SETUP) || (state_next == ST_ACCESS);
        penable_next   = (state_next == ST_ACCESS);
    end

    assign HRDATA    = hrdata_reg;
    assign HREADYOUT = hreadyout_reg;
    assign HRESP     = hresp_reg;
    assign PADDR     = paddr_reg;
    assign PSEL      = psel_reg;
    assign PENABLE   = penable_reg;
    assign PWRITE    = pwrite_reg;
    assign PWDATA    = pwdata_reg;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// ---------------------------------------------------------------------------
// tb_ahb_apb_bridge
//   Self-checking bench for ahb_apb_bridge (TIMEOUT=4). A directed vector
//   table, hand-written corner sequences (BUSY, HREADY=0, back-to-back,
//   reset during ACCESS) and randomized transfers checked against a
//   transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_ahb_apb_bridge;

    localparam int T = 4;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [15:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int n_checks = 0;
    int n_fail   = 0;
    int n_xfer   = 0;
    logic [31:0] model_hrdata;

    ahb_apb_bridge #(.APB_AW(16), .TIMEOUT(T), .CNT_W(8)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .PADDR     (PADDR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          nw;         // ACCESS cycles with PREADY=0 before PREADY=1
        bit          err;        // PSLVERR on the completing cycle
        int          exp_waits;  // cycles with HREADYOUT=0
        bit          exp_resp;
        logic [31:0] exp_hrdata;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_cycle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HREADY = 1'b1;
        @(negedge HCLK);
    endtask

    // Transaction-level reference: wait count, final response and the
    // HRDATA value visible once the transfer has finished.
    task automatic ref_model(input bit wr, input int nw, input bit err,
                             input logic [31:0] prdata,
                             output int waits, output bit resp);
        if (nw >= T) begin
            waits = T + 3;
            resp  = 1'b1;
        end else if (err) begin
            waits = nw + 4;
            resp  = 1'b1;
        end else begin
            waits = nw + 3;
            resp  = 1'b0;
            if (!wr) model_hrdata = prdata;
        end
    endtask

    // Starts at a negedge (address phase driven immediately) and returns at
    // the negedge of the first HREADYOUT=1 cycle, so a following call issues
    // its address phase back-to-back in the DONE/ERR2 cycle.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] prdata, input int nw, input bit err,
                        input int exp_waits, input bit exp_resp, input logic [31:0] exp_hr);
        int waits = 0;
        int acc = 0;
        int setups = 0;
        int exp_acc;
        logic resp_last = 1'b0;
        exp_acc = (nw >= T) ? T : nw + 1;
        HSEL   = 1'b1;
        HADDR  = addr;
        HTRANS = 2'b10;
        HWRITE = wr;
        HREADY = 1'b1;
        @(negedge HCLK);
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HADDR  = $urandom;
        HWRITE = ~wr;
        HWDATA = wdata;
        while (HREADYOUT == 1'b0 && waits < 40) begin
            waits++;
            resp_last = HRESP;
            check("penable_without_psel", {31'd0, PENABLE & ~PSEL}, 32'd0);
            if (PSEL) begin
                check("paddr", {16'd0, PADDR}, {16'd0, addr[15:0]});
                check("pwrite", {31'd0, PWRITE}, {31'd0, wr});
                if (wr) check("pwdata", PWDATA, wdata);
                check("hresp_during_apb", {31'd0, HRESP}, 32'd0);
            end
            if (PSEL && !PENABLE) setups++;
            if (PSEL && PENABLE) begin
                acc++;
                PREADY  = (acc > nw);
                PSLVERR = err & (acc > nw);
            end else begin
                PREADY  = 1'b0;
                PSLVERR = 1'b0;
            end
            PRDATA = PREADY ? prdata : $urandom;
            @(negedge HCLK);
            if (waits == 1) HWDATA = ~wdata;
        end
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        check("wait_cycles", waits, exp_waits);
        check("hresp_final", {31'd0, HRESP}, {31'd0, exp_resp});
        check("hresp_last_wait", {31'd0, resp_last}, {31'd0, exp_resp});
        check("hrdata", HRDATA, exp_hr);
        check("setup_cycles", setups, 1);
        check("access_cycles", acc, exp_acc);
        check("psel_after", {30'd0, PSEL, PENABLE}, 32'd0);
        $display("xfer %0d: %s addr=%h wdata=%h nw=%0d err=%0d waits=%0d hresp=%0d hrdata=%h",
                 n_xfer, wr ? "WR" : "RD", addr, wdata, nw, err, waits, HRESP, HRDATA);
        n_xfer++;
    endtask

    initial begin
        int w;
        bit r;
        HRESETn = 1'b0;
        HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = '0;
        HREADY = 1'b1; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        model_hrdata = '0;

        //                wr  addr           wdata          prdata         nw err waits resp hrdata
        vecs[0] = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0,         0, 1'b0, 3, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_0020, 32'h0,         32'h1234_5678, 2, 1'b0, 5, 1'b0, 32'h1234_5678};
        vecs[2] = '{1'b1, 32'h0000_0004, 32'h0BAD_CAFE, 32'h9999_9999, 0, 1'b1, 4, 1'b1, 32'h1234_5678};
        vecs[3] = '{1'b1, 32'h0001_ABCD, 32'h1111_2222, 32'h0,         9, 1'b0, 7, 1'b1, 32'h1234_5678};
        vecs[4] = '{1'b0, 32'hFFFF_0100, 32'h0,         32'h0000_0001, 4, 1'b0, 7, 1'b1, 32'h1234_5678};
        vecs[5] = '{1'b0, 32'h0000_0200, 32'h0,         32'hCAFE_F00D, 0, 1'b0, 3, 1'b0, 32'hCAFE_F00D};
        vecs[6] = '{1'b0, 32'h0000_0300, 32'h0,         32'h5555_5555, 3, 1'b0, 6, 1'b0, 32'h5555_5555};
        vecs[7] = '{1'b0, 32'h0000_0400, 32'h0,         32'h7777_7777, 1, 1'b1, 5, 1'b1, 32'h5555_5555};

        @(negedge HCLK);
        check("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check("rst_hresp",     {31'd0, HRESP}, 32'd0);
        check("rst_hrdata",    HRDATA, 32'd0);
        check("rst_psel_pen",  {30'd0, PSEL, PENABLE}, 32'd0);
        check("rst_pwrite",    {31'd0, PWRITE}, 32'd0);
        check("rst_paddr",     {16'd0, PADDR}, 32'd0);
        check("rst_pwdata",    PWDATA, 32'd0);
        HRESETn = 1'b1;
        idle_cycle();

        // Directed table; vecs[4] follows vecs[3] back-to-back in ERR2.
        for (int i = 0; i < 8; i++) begin
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].prdata, vecs[i].nw,
                 vecs[i].err, vecs[i].exp_waits, vecs[i].exp_resp, vecs[i].exp_hrdata);
            if (i != 3) idle_cycle();
        end
        model_hrdata = 32'h5555_5555;

        // BUSY with HSEL=1: OKAY, zero wait, no APB activity.
        HSEL = 1'b1; HTRANS = 2'b01; HREADY = 1'b1; HADDR = 32'h10;
        @(negedge HCLK);
        check("busy_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check("busy_hresp", {31'd0, HRESP}, 32'd0);
        check("busy_psel", {31'd0, PSEL}, 32'd0);
        @(negedge HCLK);
        check("busy_psel2", {31'd0, PSEL}, 32'd0);

        // NONSEQ while bus HREADY=0: must not be captured.
        HTRANS = 2'b10; HREADY = 1'b0;
        @(negedge HCLK);
        check("hready0_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        idle_cycle();
        check("hready0_psel", {31'd0, PSEL}, 32'd0);
        idle_cycle();
        check("hready0_psel2", {31'd0, PSEL}, 32'd0);

        // Back-to-back: second NONSEQ presented in the DONE cycle.
        xfer(1'b1, 32'h0000_0040, 32'hA5A5_5A5A, 32'h0, 0, 1'b0, 3, 1'b0, model_hrdata);
        xfer(1'b0, 32'h0000_0044, 32'h0, 32'h0F0F_0F0F, 1, 1'b0, 4, 1'b0, 32'h0F0F_0F0F);
        model_hrdata = 32'h0F0F_0F0F;
        idle_cycle();

        // Reset asserted during ACCESS: outputs forced before the next edge.
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h0000_0088;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00;
        @(negedge HCLK);
        @(negedge HCLK);
        check("pre_rst_access", {30'd0, PSEL, PENABLE}, 32'd3);
        #2 HRESETn = 1'b0;
        #1;
        check("async_rst_psel_pen", {30'd0, PSEL, PENABLE}, 32'd0);
        check("async_rst_hresp", {31'd0, HRESP}, 32'd0);
        check("async_rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check("async_rst_hrdata", HRDATA, 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        model_hrdata = '0;
        idle_cycle();
        xfer(1'b0, 32'h0000_0090, 32'h0, 32'h2468_ACE0, 0, 1'b0, 3, 1'b0, 32'h2468_ACE0);
        model_hrdata = 32'h2468_ACE0;
        idle_cycle();

        // Randomized transfers against the reference model.
        for (int i = 0; i < 60; i++) begin
            bit          wr;
            int          nw;
            bit          err;
            logic [31:0] addr;
            logic [31:0] wdata;
            logic [31:0] prdata;
            wr     = 1'($urandom_range(0, 1));
            nw     = $urandom_range(0, 6);
            err    = ($urandom_range(0, 5) == 0);
            addr   = $urandom;
            wdata  = $urandom;
            prdata = $urandom;
            ref_model(wr, nw, err, prdata, w, r);
            xfer(wr, addr, wdata, prdata, nw, err, w, r, model_hrdata);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_apb_bridge.md
Name: ahb_apb_bridge

Overview:
AHB-Lite responder that terminates single-word AHB transfers from AHB_MASTER and re-issues each one as an APB3 transfer to one downstream peripheral. It sits beside the memory and UART slaves and is selected by its own HSEL line from AHB_Decoder. Its HRDATA and HREADYOUT feed AHB_MUX. It inserts wait states until the APB transfer completes and maps PSLVERR and timeouts onto an AHB two-cycle ERROR response.

Parameters:
APB_AW, 16, PADDR width; PADDR = HADDR[APB_AW-1:0]
TIMEOUT, 255, maximum ACCESS cycles waiting for PREADY; 0 disables the timeout
CNT_W, 8, timeout counter width; requires 2^CNT_W > TIMEOUT

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  slave select from decoder
HADDR  in  32  AHB address
HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
HWRITE  in  1  1 = write
HWDATA  in  32  write data, valid in data phase
HREADY  in  1  bus HREADY, the muxed value
HRDATA  out  32  read data
HREADYOUT  out  1  0 = insert wait state
HRESP  out  1  0 OKAY, 1 ERROR
PADDR  out  APB_AW  APB address
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  32  APB write data
PRDATA  in  32  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error

Behaviour:
- Clock and reset: one clock, HCLK; reset HRESETn is asynchronous and active-low. All outputs are registered.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0. State = IDLE, timeout counter = 0.
- Reset mid-transfer: all of the above are forced immediately, asynchronously; the in-flight APB transfer is dropped.
- Capture condition is HSEL & HTRANS[1] & HREADY. It is evaluated in IDLE, DONE and ERR2 only. On capture, latch HADDR[APB_AW-1:0] and HWRITE, then go to LATCH.
- BUSY/IDLE transfers and unselected cycles produce an OKAY zero-wait response and no APB activity.
- States and transitions:
  - IDLE: HREADYOUT=1, HRESP=0, PSEL=0. Capture → LATCH.
  - LATCH: this is the AHB data-phase cycle. HREADYOUT=0. Register PWDATA<=HWDATA if write; PWDATA holds its value on reads. Drive PADDR and PWRITE from the latch. → SETUP.
  - SETUP: PSEL=1, PENABLE=0, HREADYOUT=0, counter cleared. → ACCESS.
  - ACCESS: PSEL=1, PENABLE=1, HREADYOUT=0.
    - PREADY=1 and PSLVERR=0 → DONE; on a read, HRDATA<=PRDATA.
    - PREADY=1 and PSLVERR=1 → ERR1; HRDATA is unchanged.
    - PREADY=0: counter increments. When TIMEOUT≠0 and the counter reaches TIMEOUT → ERR1.
  - DONE: PSEL=0, PENABLE=0, HREADYOUT=1, HRESP=0. Capture → LATCH, else → IDLE.
  - ERR1: PSEL=0, PENABLE=0, HREADYOUT=0, HRESP=1. → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Capture → LATCH, else → IDLE.
- Latency with zero-wait APB: address phase in cycle N; LATCH N+1; SETUP N+2; ACCESS N+3. HREADYOUT is 1 and HRDATA is valid in N+4. Each PREADY=0 cycle adds one cycle.
- APB rules:
  - PADDR, PWRITE and PWDATA are stable from SETUP through the last ACCESS cycle.
  - PENABLE is never 1 without PSEL.
  - PSEL drops in the cycle after completion; there are no back-to-back APB transfers without SETUP.
- HRDATA holds its last read value across writes, errors and idle cycles.
- Timeout boundary: with TIMEOUT=T, the transfer is aborted after exactly T consecutive ACCESS cycles with PREADY=0. PREADY=1 in the T-th cycle counts as a normal completion.
- HREADY=0 caused by another slave means no capture, even if HSEL=1 and HTRANS=NONSEQ.

Test Plan:
- Reset, then a write: HADDR=0x8000_0010, HWDATA=0xDEAD_BEEF, PREADY=1 → PADDR=0x0010, PWRITE=1, PWDATA=0xDEAD_BEEF in SETUP and ACCESS. HREADYOUT is low for 3 cycles then high, HRESP=0.
- Read with PREADY low for 2 cycles, PRDATA=0x1234_5678 → 5 wait cycles, HRDATA=0x1234_5678 when HREADYOUT=1.
- PSLVERR=1 on write completion → HRESP=1 with HREADYOUT=0 for one cycle, then HRESP=1 with HREADYOUT=1. HRDATA is unchanged.
- TIMEOUT=4, PREADY held 0 → PSEL drops after 4 ACCESS cycles, then a two-cycle ERROR. A following NONSEQ read completes normally.
- Back-to-back NONSEQ transfers presented in the DONE cycle, and HTRANS=BUSY with HSEL=1 → the second transfer is captured without an IDLE gap; BUSY gives HREADYOUT=1, HRESP=0, PSEL=0.
- HRESETn asserted during ACCESS → PSEL, PENABLE and HRESP are 0 and HREADYOUT is 1 immediately, before the next edge. After release, a read completes normally.
